keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Parametrised scanner for an active-low ROWS×COLS key matrix. It succeeds the fixed 4×4 keypad controller. It drives the row lines one at a time, synchronises and debounces the column returns per key, and maintains a debounced key-state vector. It queues key events in a FIFO with a valid/ready handshake toward the ALU or any other consumer, and reports a sticky overflow flag when events are lost.

## Interface
- ROWS, 4, number of row lines (driven), 1..8
- COLS, 4, number of column lines (sensed), 1..8
- SETTLE_CYCLES, 16, cycles each row is held low before columns are sampled, ≥3
- DEBOUNCE_FRAMES, 3, consecutive full frames a key's raw state must disagree with its debounced state before it flips, ≥1
- FIFO_DEPTH, 4, event queue entries, power of two ≥2
- CODE_W, derived $clog2(ROWS*COLS) (min 1), event code width

- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- rowN  out  ROWS  one-hot-low row drive; bit r low while row r is scanned
- columnN  in  COLS  raw active-low column returns, asynchronous to clk
- evt_valid  out  1  head of FIFO holds an event
- evt_ready  in  1  consumer accepts head event
- evt_code  out  CODE_W  key index = row*COLS + col
- evt_release  out  1  1 = release event, 0 = press event
- keys_down  out  ROWS*COLS  debounced state, bit = key index
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Columns pass through a 2-FF synchroniser before use.
- Scan FSM states: SETTLE (row r driven low, counter 0..SETTLE_CYCLES-1), then EVAL (col c = 0..COLS-1, one key per cycle), then advance r (wrapping ROWS-1→0) back to SETTLE. The row stays driven through EVAL. The synchronised column word is latched on the last SETTLE cycle.
- Per key there is a debounce counter of width $clog2(DEBOUNCE_FRAMES+1). In EVAL, for key k: if raw≠keys_down[k], increment; when the count reaches DEBOUNCE_FRAMES, toggle keys_down[k], reset the count and generate an event. If raw==keys_down[k], reset the count to 0.
- Press event (0→1): always generated. Release event (1→0): see Configuration.
- At most one event per cycle, so there are no simultaneous-push conflicts.
- FIFO push when full: the event is discarded, overflow is set, and keys_down still updates.
- Pop occurs when evt_valid && evt_ready. A push and a pop in the same cycle while full are both accepted, with no overflow.
- evt_code and evt_release hold stable while evt_valid && !evt_ready.
- ovf_clr together with a same-cycle drop leaves overflow set.

## Timing
- Reset values: rowN all 1, evt_valid 0, evt_code 0, evt_release 0, keys_down 0, overflow 0. FIFO is empty, debounce counters are 0, FSM is at SETTLE with r=0.
- First cycle after reset_n rises: rowN = ~(1<<0).
- Row period = SETTLE_CYCLES + COLS cycles. Frame = ROWS × row period.
- Event generated in EVAL cycle t → evt_valid high at t+1. Registered FIFO with no fall-through.
- Press latency from stable input: at most (DEBOUNCE_FRAMES+1) frames + 2 synchroniser cycles.
- reset_n low mid-operation clears everything immediately (asynchronous). Queued events are lost.

## Configuration
- KEYPAD_RELEASE_EVT_EN defined: 1→0 debounced transitions push an event with evt_release=1.
- KEYPAD_RELEASE_EVT_EN undefined: release transitions update keys_down only. No event is pushed, and evt_release is tied to 0.

## Test plan
Bench parameters: ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3, FIFO_DEPTH=4, giving a 32-cycle frame.

- **Reset and scan order:** reset_n low → rowN=4'b1111, outputs 0. Release reset → rowN cycles 1110, 1101, 1011, 0111, each for 8 cycles, then wraps.
- **Single press:** hold key row2/col1 (columnN[1] low whenever rowN[2] is low) → exactly one event, code 9, release 0; keys_down[9]=1 within 4 frames. evt_ready=1 pops it the next cycle.
- **Bounce rejection:** assert key 9 for 2 frames, release for 1 frame, repeat → no event, keys_down stays 0.
- **Overflow:** evt_ready=0, press keys 0, 5, 10, 15, 3 in turn → 4 events queued, overflow=1, key 3 event lost, keys_down[3]=1. Pulse ovf_clr → overflow=0. Drain → codes 0, 5, 10, 15 in order.
- **Release event:** with key 9 down, release it. With the macro defined → event code 9, release=1. Without the macro → no event, keys_down[9]=0.
- **Mid-operation reset:** 2 events queued, pull reset_n low between clock edges → evt_valid=0 and rowN=4'b1111 before the next edge. After release, the FIFO is empty.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad controller: per-key debounce, debounced key map and an event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue release events; otherwise only presses are queued.
module keypad_matrix_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int CODE_W          = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [ROWS-1:0]        rowN,
  input  logic [COLS-1:0]        columnN,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CODE_W-1:0]      evt_code,
  output logic                   evt_release,
  output logic [ROWS*COLS-1:0]   keys_down,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int KEYS = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW   = $clog2(SETTLE_CYCLES);
  localparam int DW   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  typedef enum logic {SETTLE, EVAL} state_t;

  state_t            state;
  logic              started;
  logic [SW-1:0]     settle_cnt;
  logic [RW-1:0]     row;
  logic [RW-1:0]     next_row;
  logic [CW-1:0]     col;
  logic [COLS-1:0]   col_meta;
  logic [COLS-1:0]   col_sync;
  logic [COLS-1:0]   col_latched;
  logic [DW-1:0]     deb_cnt [KEYS];

  logic [CODE_W-1:0] cur_key;
  logic              raw_down;
  logic              mismatch;
  logic              flip;
  logic              push;

  logic [CODE_W-1:0] code_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              pop;
  logic              accept;
  logic              drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= columnN;
      col_sync <= col_meta;
    end
  end

  always_comb begin
    cur_key  = CODE_W'(int'(row) * COLS + int'(col));
    raw_down = ~col_latched[col];
    mismatch = (state == EVAL) && (raw_down != keys_down[cur_key]);
    flip     = mismatch && (deb_cnt[cur_key] == DW'(DEBOUNCE_FRAMES - 1));
    push     = flip && (raw_down || REL_EN);
    next_row = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
  end

  // The first cycle after reset only starts driving row 0, so every row gets a full settle window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SETTLE;
      started     <= 1'b0;
      settle_cnt  <= '0;
      row         <= '0;
      col         <= '0;
      col_latched <= '1;
      rowN        <= '1;
      keys_down   <= '0;
      for (int k = 0; k < KEYS; k++) deb_cnt[k] <= '0;
    end else if (!started) begin
      started <= 1'b1;
      rowN    <= ~ROWS'(1);
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt  <= '0;
            col_latched <= col_sync;
            col         <= '0;
            state       <= EVAL;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        EVAL: begin
          if (flip) begin
            keys_down[cur_key] <= raw_down;
            deb_cnt[cur_key]   <= '0;
          end else if (mismatch) begin
            deb_cnt[cur_key] <= deb_cnt[cur_key] + 1'b1;
          end else begin
            deb_cnt[cur_key] <= '0;
          end
          if (col == CW'(COLS - 1)) begin
            col   <= '0;
            row   <= next_row;
            rowN  <= ~(ROWS'(1) << next_row);
            state <= SETTLE;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  assign evt_valid = (count != '0);
  assign full      = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign evt_code  = code_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) code_mem[i] <= '0;
    end else begin
      if (accept) begin
        code_mem[wr_ptr] <= cur_key;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  logic rel_mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rel_mem[i] <= 1'b0;
    end else if (accept) begin
      rel_mem[wr_ptr] <= ~raw_down;
    end
  end

  assign evt_release = rel_mem[rd_ptr];
`else
  assign evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: behavioural key matrix, event scoreboard queue, scenario tasks.
module tb_keypad_matrix_scanner;
  localparam int FRAME = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  rowN;
  logic [3:0]  columnN;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_code;
  logic        evt_release;
  logic [15:0] keys_down;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  logic [15:0] held = '0;
  int checks_total = 0;
  int checks_passed = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       rel;
  } evt_t;
  evt_t exp_q[$];

  always #5 clk = ~clk;

  // Ideal matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    columnN = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rowN[r] && held[r*4+c]) columnN[c] = 1'b0;
  end

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rowN(rowN), .columnN(columnN),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_release(evt_release), .keys_down(keys_down), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", checks_passed, checks_total);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [3:0] exp_row;
    reset_n = 1'b0; held = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks_total++; if (rowN !== 4'b1111) $display("FAIL reset_rowN: got %b expected 1111", rowN); else checks_passed++;
    checks_total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid: got %b expected 0", evt_valid); else checks_passed++;
    checks_total++; if (evt_code !== 4'd0) $display("FAIL reset_evt_code: got %0d expected 0", evt_code); else checks_passed++;
    checks_total++; if (evt_release !== 1'b0) $display("FAIL reset_evt_release: got %b expected 0", evt_release); else checks_passed++;
    checks_total++; if (keys_down !== 16'h0000) $display("FAIL reset_keys_down: got %h expected 0000", keys_down); else checks_passed++;
    checks_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else checks_passed++;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((i / 8) % 4));
      checks_total++;
      if (rowN !== exp_row) $display("FAIL scan_order: cycle %0d got %b expected %b", i, rowN, exp_row);
      else checks_passed++;
    end
  endtask

  task automatic test_single_press();
    evt_t e;
    bit found, stable, extra;
    evt_ready = 1'b0;
    held[9] = 1'b1;
    exp_q.push_back('{code: 4'd9, rel: 1'b0});
    found = 0;
    for (int i = 0; i < 4 * FRAME + 8; i++) begin
      @(negedge clk);
      if (evt_valid) begin found = 1; break; end
    end
    checks_total++; if (!found) $display("FAIL press_timeout: got no event expected event within 4 frames"); else checks_passed++;
    e = exp_q[0];
    checks_total++; if (evt_code !== e.code) $display("FAIL press_code: got %0d expected %0d", evt_code, e.code); else checks_passed++;
    checks_total++; if (evt_release !== e.rel) $display("FAIL press_release: got %b expected %b", evt_release, e.rel); else checks_passed++;
    checks_total++; if (keys_down !== 16'h0200) $display("FAIL press_keys_down: got %h expected 0200", keys_down); else checks_passed++;
    $display("event code=%0d release=%0d", evt_code, evt_release);
    stable = 1;
    repeat (3) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_code !== e.code) stable = 0;
    end
    checks_total++; if (!stable) $display("FAIL press_hold: got valid=%b code=%0d expected valid=1 code=%0d", evt_valid, evt_code, e.code); else checks_passed++;
    evt_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks_total++; if (evt_valid !== 1'b0) $display("FAIL press_pop: got valid=%b expected 0", evt_valid); else checks_passed++;
    extra = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (evt_valid) extra = 1;
    end
    checks_total++; if (extra) $display("FAIL press_single: got extra event expected none"); else checks_passed++;
    checks_total++; if (keys_down !== 16'h0200) $display("FAIL press_keys_hold: got %h expected 0200", keys_down); else checks_passed++;
  endtask

  task automatic test_release();
    evt_t e;
    bit found, extra;
    evt_ready = 1'b0;
    held[9] = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back('{code: 4'd9, rel: 1'b1});
`endif
    found = 0;
    for (int i = 0; i < 4 * FRAME + 8; i++) begin
      @(negedge clk);
      if (keys_down[9] === 1'b0) begin found = 1; break; end
    end
    checks_total++; if (!found) $display("FAIL release_keys_down: got %h expected 0000", keys_down); else checks_passed++;
`ifdef KEYPAD_RELEASE_EVT_EN
    e = exp_q[0];
    checks_total++; if (evt_valid !== 1'b1) $display("FAIL release_valid: got %b expected 1", evt_valid); else checks_passed++;
    checks_total++; if (evt_code !== e.code) $display("FAIL release_code: got %0d expected %0d", evt_code, e.code); else checks_passed++;
    checks_total++; if (evt_release !== e.rel) $display("FAIL release_flag: got %b expected %b", evt_release, e.rel); else checks_passed++;
    $display("event code=%0d release=%0d", evt_code, evt_release);
    evt_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks_total++; if (evt_valid !== 1'b0) $display("FAIL release_pop: got %b expected 0", evt_valid); else checks_passed++;
`else
    extra = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (evt_valid) extra = 1;
    end
    checks_total++; if (extra) $display("FAIL release_no_event: got event expected none"); else checks_passed++;
    checks_total++; if (evt_release !== 1'b0) $display("FAIL release_tied: got %b expected 0", evt_release); else checks_passed++;
`endif
  endtask

  task automatic test_bounce();
    bit saw;
    evt_ready = 1'b0;
    saw = 0;
    repeat (3) begin
      held[9] = 1'b1;
      repeat (2 * FRAME) begin @(negedge clk); if (evt_valid) saw = 1; end
      held[9] = 1'b0;
      repeat (FRAME) begin @(negedge clk); if (evt_valid) saw = 1; end
    end
    repeat (FRAME + 8) begin @(negedge clk); if (evt_valid) saw = 1; end
    checks_total++; if (saw) $display("FAIL bounce_event: got event expected none"); else checks_passed++;
    checks_total++; if (keys_down !== 16'h0000) $display("FAIL bounce_keys_down: got %h expected 0000", keys_down); else checks_passed++;
  endtask

  task automatic test_overflow();
    int key_list[5];
    evt_t e;
    bit found;
    int pops;
    key_list = '{0, 5, 10, 15, 3};
    evt_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      held[key_list[n]] = 1'b1;
      if (n < 4) exp_q.push_back('{code: 4'(key_list[n]), rel: 1'b0});
      found = 0;
      for (int i = 0; i < 5 * FRAME; i++) begin
        @(negedge clk);
        if (keys_down[key_list[n]] === 1'b1) begin found = 1; break; end
      end
      checks_total++; if (!found) $display("FAIL ovf_press_%0d: got keys_down %h expected bit set", key_list[n], keys_down); else checks_passed++;
      if (n == 3) begin
        checks_total++; if (overflow !== 1'b0) $display("FAIL ovf_full_no_drop: got %b expected 0", overflow); else checks_passed++;
      end
    end
    checks_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else checks_passed++;
    checks_total++; if (keys_down !== 16'h8429) $display("FAIL ovf_keys_down: got %h expected 8429", keys_down); else checks_passed++;
    checks_total++; if (evt_code !== exp_q[0].code) $display("FAIL ovf_head: got %0d expected %0d", evt_code, exp_q[0].code); else checks_passed++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow); else checks_passed++;
    evt_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (evt_valid) begin
        $display("event code=%0d release=%0d", evt_code, evt_release);
        checks_total++;
        if (exp_q.size() == 0) $display("FAIL drain_extra: got code %0d expected no event", evt_code);
        else begin
          e = exp_q.pop_front();
          if (evt_code !== e.code || evt_release !== e.rel)
            $display("FAIL drain_code: got %0d/%b expected %0d/%b", evt_code, evt_release, e.code, e.rel);
          else checks_passed++;
        end
        pops++;
      end
      @(negedge clk);
    end
    checks_total++; if (pops != 4) $display("FAIL drain_count: got %0d expected 4", pops); else checks_passed++;
    checks_total++; if (evt_valid !== 1'b0) $display("FAIL drain_empty: got %b expected 0", evt_valid); else checks_passed++;
  endtask

  task automatic test_mid_reset();
    bit found, extra;
    @(negedge clk);
    reset_n = 1'b0; held = '0; evt_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      held[n == 0 ? 1 : 6] = 1'b1;
      exp_q.push_back('{code: (n == 0) ? 4'd1 : 4'd6, rel: 1'b0});
      found = 0;
      for (int i = 0; i < 5 * FRAME; i++) begin
        @(negedge clk);
        if (keys_down[n == 0 ? 1 : 6] === 1'b1) begin found = 1; break; end
      end
      checks_total++; if (!found) $display("FAIL mid_press_%0d: got keys_down %h expected bit set", n, keys_down); else checks_passed++;
    end
    checks_total++; if (evt_valid !== 1'b1 || evt_code !== exp_q[0].code)
      $display("FAIL mid_queued_head: got valid=%b code=%0d expected valid=1 code=%0d", evt_valid, evt_code, exp_q[0].code);
    else checks_passed++;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks_total++; if (evt_valid !== 1'b0) $display("FAIL mid_async_valid: got %b expected 0", evt_valid); else checks_passed++;
    checks_total++; if (rowN !== 4'b1111) $display("FAIL mid_async_rowN: got %b expected 1111", rowN); else checks_passed++;
    checks_total++; if (keys_down !== 16'h0000) $display("FAIL mid_async_keys: got %h expected 0000", keys_down); else checks_passed++;
    held = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks_total++; if (rowN !== 4'b1110) $display("FAIL mid_restart_row: got %b expected 1110", rowN); else checks_passed++;
    extra = 0;
    repeat (2 * FRAME) begin @(negedge clk); if (evt_valid) extra = 1; end
    checks_total++; if (extra) $display("FAIL mid_fifo_empty: got event expected empty FIFO"); else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
